step_position_tracker: RTL and testbench

STEP_POSITION_TRACKER -- requirements
Module: step_position_tracker

---
 rtl/elevator_pkg.sv | 18 +
 rtl/coil_phase_filter.sv | 35 +++
 rtl/step_position_tracker.sv | 146 ++++++++++++++
 tb/tb_step_position_tracker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator stepper position tracker.
// Holds the tracker state encoding and the one-hot coil patterns for each motor phase.
package elevator_pkg;

  typedef enum logic [1:0] {
    UNCAL = 2'd0,
    IDLE  = 2'd1,
    MOVE  = 2'd2,
    FAULT = 2'd3
  } tracker_state_t;

  localparam logic [3:0] PHASE0    = 4'b0001;
  localparam logic [3:0] PHASE1    = 4'b0010;
  localparam logic [3:0] PHASE2    = 4'b0100;
  localparam logic [3:0] PHASE3    = 4'b1000;
  localparam logic [3:0] COILS_OFF = 4'b0000;

endpackage

// File: rtl/coil_phase_filter.sv
// Brings the asynchronous coil pattern into the clk domain and only passes on
// patterns that hold steady for two synchronized cycles, with a one-cycle update strobe.
module coil_phase_filter
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] coil,
  output logic [3:0] pattern,
  output logic       update
);

  logic [3:0] sync1, sync2, sync3;

  // sync3 is the previous synchronized sample, so sync2==sync3 means two stable cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= COILS_OFF;
      sync2   <= COILS_OFF;
      sync3   <= COILS_OFF;
      pattern <= COILS_OFF;
      update  <= 1'b0;
    end else begin
      sync1  <= coil;
      sync2  <= sync1;
      sync3  <= sync2;
      update <= 1'b0;
      if (sync2 == sync3 && sync2 != pattern) begin
        pattern <= sync2;
        update  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_position_tracker.sv
// Tracks elevator car position by counting stepper motor phase transitions,
// with calibration, motion timeout and sticky fault detection.
module step_position_tracker
  import elevator_pkg::*;
#(
  parameter int STEPS_PER_FLOOR = 2048,
  parameter int NUM_FLOORS      = 8,
  parameter int TIMEOUT         = 460000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  coil,
  input  logic        cal,
  output logic [3:0]  floor,
  output logic [15:0] step_in_floor,
  output logic        at_floor,
  output logic        moving,
  output logic        dir_up,
  output logic        step_pulse,
  output logic        fault
);

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [15:0] LAST_STEP = 16'(STEPS_PER_FLOOR - 1);
  localparam logic [3:0]  TOP_FLOOR = 4'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  logic [3:0]     pattern;
  logic           update;
  tracker_state_t state, state_nx;
  logic [1:0]     phase_ref, phase_ref_nx, pattern_phase, delta;
  logic           pattern_valid, pattern_bad;
  logic           step_up, step_dn, skip, calibrated, limit, fault_cond, accept;
  logic [3:0]     floor_nx;
  logic [15:0]    step_nx;
  logic           dir_nx, pulse_nx;
  logic [TW-1:0]  timer, timer_nx;

  coil_phase_filter u_filter (
    .clk     (clk),
    .reset   (reset),
    .coil    (coil),
    .pattern (pattern),
    .update  (update)
  );

  always_comb begin
    pattern_valid = 1'b1;
    pattern_bad   = 1'b0;
    pattern_phase = 2'd0;
    case (pattern)
      PHASE0:    pattern_phase = 2'd0;
      PHASE1:    pattern_phase = 2'd1;
      PHASE2:    pattern_phase = 2'd2;
      PHASE3:    pattern_phase = 2'd3;
      COILS_OFF: pattern_valid = 1'b0;
      default: begin
        pattern_valid = 1'b0;
        pattern_bad   = 1'b1;
      end
    endcase
  end

  // Step legality: skips and limits only count once calibrated; garbage patterns always do
  always_comb begin
    delta      = pattern_phase - phase_ref;
    step_up    = update && pattern_valid && (delta == 2'd1);
    step_dn    = update && pattern_valid && (delta == 2'd3);
    skip       = update && pattern_valid && (delta == 2'd2);
    calibrated = (state == IDLE) || (state == MOVE);
    limit      = calibrated &&
                 ((step_up && floor == TOP_FLOOR && step_in_floor == 16'd0) ||
                  (step_dn && floor == 4'd0 && step_in_floor == 16'd0));
    fault_cond = (update && pattern_bad) || (calibrated && skip) || limit;
    accept     = calibrated && (step_up || step_dn) && !limit;
  end

  always_comb begin
    state_nx     = state;
    phase_ref_nx = (update && pattern_valid) ? pattern_phase : phase_ref;
    floor_nx     = floor;
    step_nx      = step_in_floor;
    dir_nx       = dir_up;
    pulse_nx     = 1'b0;
    timer_nx     = timer;
    if (cal) begin
      state_nx     = IDLE;
      floor_nx     = 4'd0;
      step_nx      = 16'd0;
      timer_nx     = '0;
      phase_ref_nx = pattern_valid ? pattern_phase : phase_ref;
    end else if (fault_cond) begin
      state_nx = FAULT;
    end else if (accept) begin
      state_nx = MOVE;
      timer_nx = '0;
      pulse_nx = 1'b1;
      dir_nx   = step_up;
      if (step_up) begin
        if (step_in_floor == LAST_STEP) begin
          step_nx  = 16'd0;
          floor_nx = floor + 4'd1;
        end else begin
          step_nx = step_in_floor + 16'd1;
        end
      end else if (step_in_floor == 16'd0) begin
        step_nx  = LAST_STEP;
        floor_nx = floor - 4'd1;
      end else begin
        step_nx = step_in_floor - 16'd1;
      end
    end else if (state == MOVE) begin
      if (timer == TIMER_END) begin
        state_nx = IDLE;
        timer_nx = '0;
      end else begin
        timer_nx = timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= UNCAL;
      phase_ref     <= 2'd0;
      floor         <= 4'd0;
      step_in_floor <= 16'd0;
      dir_up        <= 1'b0;
      step_pulse    <= 1'b0;
      timer         <= '0;
    end else begin
      state         <= state_nx;
      phase_ref     <= phase_ref_nx;
      floor         <= floor_nx;
      step_in_floor <= step_nx;
      dir_up        <= dir_nx;
      step_pulse    <= pulse_nx;
      timer         <= timer_nx;
    end
  end

  assign moving   = (state == MOVE);
  assign fault    = (state == FAULT);
  assign at_floor = (state == IDLE) && (step_in_floor == 16'd0);

endmodule

// File: tb/tb_step_position_tracker.sv
// Directed self-checking bench for step_position_tracker: calibration, stepping,
// floor wrap, timeout, fault cases and reset behaviour.
module tb_step_position_tracker;
  import elevator_pkg::*;

  localparam int SPF = 2048;
  localparam int NF  = 8;
  localparam int TO  = 5000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cal = 1'b0;
  logic [3:0]  coil = 4'b0000;
  logic [3:0]  floor;
  logic [15:0] step_in_floor;
  logic        at_floor, moving, dir_up, step_pulse, fault;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   last_pulse_cyc = 0;
  int   fall_cyc = 0;
  int   ph = 0;
  int   p0 = 0;
  logic prev_moving = 1'b0;

  step_position_tracker #(
    .STEPS_PER_FLOOR (SPF),
    .NUM_FLOORS      (NF),
    .TIMEOUT         (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .coil          (coil),
    .cal           (cal),
    .floor         (floor),
    .step_in_floor (step_in_floor),
    .at_floor      (at_floor),
    .moving        (moving),
    .dir_up        (dir_up),
    .step_pulse    (step_pulse),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // Pulse counting and moving-edge timestamps, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (step_pulse) begin
      pulses = pulses + 1;
      last_pulse_cyc = cyc;
    end
    if (prev_moving && !moving) fall_cyc = cyc;
    prev_moving = moving;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int dirn, input int hold);
    ph   = (ph + dirn + 4) % 4;
    coil = 4'(1 << ph);
    repeat (hold) @(negedge clk);
  endtask

  task automatic calibrate();
    cal = 1'b1;
    @(negedge clk);
    cal = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_floor"}, 32'(floor), 32'd0);
    checkOutput({tag, "_step"}, 32'(step_in_floor), 32'd0);
    checkOutput({tag, "_at_floor"}, 32'(at_floor), 32'd0);
    checkOutput({tag, "_moving"}, 32'(moving), 32'd0);
    checkOutput({tag, "_dir_up"}, 32'(dir_up), 32'd0);
    checkOutput({tag, "_pulse"}, 32'(step_pulse), 32'd0);
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    checkOutput({tag, "_state"}, 32'(dut.state), 32'(UNCAL));
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkAllLow("in_reset");
    reset = 1'b0;
    ph = 0;
    coil = 4'b0001;
    repeat (10) @(negedge clk);
    checkAllLow("after_reset");

    calibrate();
    checkOutput("cal_state", 32'(dut.state), 32'(IDLE));
    checkOutput("cal_at_floor", 32'(at_floor), 32'd1);

    // Four single up steps through a full phase cycle
    p0 = pulses;
    repeat (4) applyStimulus(1, 10);
    checkOutput("up4_pulses", 32'(pulses - p0), 32'd4);
    checkOutput("up4_dir", 32'(dir_up), 32'd1);
    checkOutput("up4_step", 32'(step_in_floor), 32'd4);
    checkOutput("up4_floor", 32'(floor), 32'd0);
    checkOutput("up4_moving", 32'(moving), 32'd1);

    // One-cycle glitch must be filtered out
    p0 = pulses;
    coil = 4'(1 << ((ph + 1) % 4));
    @(negedge clk);
    coil = 4'(1 << ph);
    repeat (10) @(negedge clk);
    checkOutput("glitch_pulses", 32'(pulses - p0), 32'd0);
    checkOutput("glitch_fault", 32'(fault), 32'd0);

    // Complete a whole floor of up steps
    repeat (SPF - 4) applyStimulus(1, 6);
    repeat (TO + 10) @(negedge clk);
    checkOutput("floor1_floor", 32'(floor), 32'd1);
    checkOutput("floor1_step", 32'(step_in_floor), 32'd0);
    checkOutput("floor1_at_floor", 32'(at_floor), 32'd1);
    checkOutput("floor1_moving", 32'(moving), 32'd0);

    // Down step across the floor boundary
    applyStimulus(-1, 10);
    checkOutput("wrapdn_floor", 32'(floor), 32'd0);
    checkOutput("wrapdn_step", 32'(step_in_floor), 32'd2047);
    checkOutput("wrapdn_dir", 32'(dir_up), 32'd0);

    // Slow stepping keeps moving high; timeout counted from the last pulse
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1000);
      checkOutput("slow_moving", 32'(moving), 32'd1);
    end
    applyStimulus(1, 10);
    checkOutput("slow_floor", 32'(floor), 32'd1);
    checkOutput("slow_step", 32'(step_in_floor), 32'd4);
    for (int i = 0; i < TO + 1000 && moving; i++) @(negedge clk);
    checkOutput("timeout_moving", 32'(moving), 32'd0);
    checkOutput("timeout_cycles", 32'(fall_cyc - last_pulse_cyc), 32'(TO));

    // Down step below floor 0 is a fault
    calibrate();
    checkOutput("recal_floor", 32'(floor), 32'd0);
    checkOutput("recal_step", 32'(step_in_floor), 32'd0);
    p0 = pulses;
    applyStimulus(-1, 10);
    checkOutput("bottom_fault", 32'(fault), 32'd1);
    checkOutput("bottom_state", 32'(dut.state), 32'(FAULT));
    checkOutput("bottom_step", 32'(step_in_floor), 32'd0);
    checkOutput("bottom_pulses", 32'(pulses - p0), 32'd0);
    calibrate();
    checkOutput("bottom_clear_fault", 32'(fault), 32'd0);
    checkOutput("bottom_clear_state", 32'(dut.state), 32'(IDLE));

    // Skipped phase
    p0 = pulses;
    applyStimulus(2, 10);
    checkOutput("skip_fault", 32'(fault), 32'd1);
    checkOutput("skip_pulses", 32'(pulses - p0), 32'd0);
    calibrate();

    // Two coils energised
    coil = 4'b0011;
    repeat (10) @(negedge clk);
    checkOutput("double_fault", 32'(fault), 32'd1);
    checkOutput("double_pulses", 32'(pulses - p0), 32'd0);
    coil = 4'(1 << ph);
    repeat (10) @(negedge clk);
    calibrate();
    checkOutput("double_clear", 32'(fault), 32'd0);

    // Coils off then back to the same phase is not a step
    coil = 4'b0000;
    repeat (10) @(negedge clk);
    coil = 4'(1 << ph);
    repeat (10) @(negedge clk);
    checkOutput("off_pulses", 32'(pulses - p0), 32'd0);
    checkOutput("off_fault", 32'(fault), 32'd0);

    // Reset mid-sequence, then steps without calibration
    repeat (100) applyStimulus(1, 6);
    checkOutput("run100_step", 32'(step_in_floor), 32'd100);
    checkOutput("run100_floor", 32'(floor), 32'd0);
    p0 = pulses;
    ph = (ph + 1) % 4;
    coil = 4'(1 << ph);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAllLow("mid_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    repeat (10) applyStimulus(1, 6);
    checkAllLow("uncal_steps");
    checkOutput("uncal_pulses", 32'(pulses - p0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
